// File: rtl/id_ex_hazard_reg.sv
// ID/EX pipeline register with load-use / branch-operand hazard detection,
// bubble insertion, PC and IF/ID write gating, and saturating debug counters.
module id_ex_hazard_reg #(
    parameter int W  = 32,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          id_RegWrite,
    input  logic          id_Mem_Read,
    input  logic          id_Mem_Write,
    input  logic          id_MemtoReg,
    input  logic          id_RegDst,
    input  logic [1:0]    id_ALUsrc,
    input  logic [1:0]    id_ALUop,
    input  logic [1:0]    id_branch,
    input  logic          id_flush,
    input  logic [W-1:0]  id_rd1,
    input  logic [W-1:0]  id_rd2,
    input  logic [W-1:0]  id_imm,
    input  logic [4:0]    id_rs,
    input  logic [4:0]    id_rt,
    input  logic [4:0]    id_rd,
    input  logic          mem_RegWrite,
    input  logic          mem_Mem_Read,
    input  logic [4:0]    mem_write_reg,
    output logic          ex_RegWrite,
    output logic          ex_Mem_Read,
    output logic          ex_Mem_Write,
    output logic          ex_MemtoReg,
    output logic          ex_RegDst,
    output logic [1:0]    ex_ALUsrc,
    output logic [1:0]    ex_ALUop,
    output logic [W-1:0]  ex_rd1,
    output logic [W-1:0]  ex_rd2,
    output logic [W-1:0]  ex_imm,
    output logic [4:0]    ex_rs,
    output logic [4:0]    ex_rt,
    output logic [4:0]    ex_rd,
    output logic          stall,
    output logic          pc_write,
    output logic          ifid_write,
    output logic          ifid_flush,
    output logic [CW-1:0] stall_cnt,
    output logic [CW-1:0] flush_cnt
);

    localparam int BW = 9 + 3 * W + 15;

    logic [BW-1:0] bundle_d, bundle_q;
    logic [CW-1:0] stall_cnt_d, stall_cnt_q;
    logic [CW-1:0] flush_cnt_d, flush_cnt_q;
    logic [4:0]    ex_write_reg;
    logic          load_use, br, br_ex, br_mem;

    assign {ex_RegWrite, ex_Mem_Read, ex_Mem_Write, ex_MemtoReg, ex_RegDst,
            ex_ALUsrc, ex_ALUop, ex_rd1, ex_rd2, ex_imm,
            ex_rs, ex_rt, ex_rd} = bundle_q;

    assign ex_write_reg = ex_RegDst ? ex_rd : ex_rt;

    // Register 0 is hardwired, so it never creates a dependency.
    assign load_use = ex_Mem_Read && (ex_rt != 5'd0) &&
                      ((ex_rt == id_rs) || (ex_rt == id_rt));
    assign br       = (id_branch != 2'd0);
    assign br_ex    = br && ex_RegWrite && (ex_write_reg != 5'd0) &&
                      ((ex_write_reg == id_rs) || (ex_write_reg == id_rt));
    assign br_mem   = br && mem_Mem_Read && mem_RegWrite && (mem_write_reg != 5'd0) &&
                      ((mem_write_reg == id_rs) || (mem_write_reg == id_rt));

    assign stall      = load_use || br_ex || br_mem;
    assign pc_write   = !stall;
    assign ifid_write = !stall;
    // A stalled branch re-evaluates next cycle, so its flush is held back.
    assign ifid_flush = id_flush && !stall;

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

    always_comb begin
        bundle_d    = stall ? '0 :
                      {id_RegWrite, id_Mem_Read, id_Mem_Write, id_MemtoReg, id_RegDst,
                       id_ALUsrc, id_ALUop, id_rd1, id_rd2, id_imm,
                       id_rs, id_rt, id_rd};
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall && (stall_cnt_q != {CW{1'b1}}))
            stall_cnt_d = stall_cnt_q + 1'b1;
        if (ifid_flush && (flush_cnt_q != {CW{1'b1}}))
            flush_cnt_d = flush_cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bundle_q    <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            bundle_q    <= bundle_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

endmodule

// File: doc/id_ex_hazard_reg.md
Name: id_ex_hazard_reg

Overview:
- ID/EX pipeline register for the 5-stage MIPS core.
- Captures the main opcode controller's control bundle and the ID-stage operands, and hands them to EX.
- Also detects load-use and branch-operand hazards, inserts bubbles, gates PC and IF/ID writes, and qualifies the controller's flush.
- Keeps saturating stall and flush event counters for debug.

Parameters:
- W, 32, datapath width of operands and immediate.
- CW, 16, width of the stall_cnt and flush_cnt counters.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- id_RegWrite, id_Mem_Read, id_Mem_Write, id_MemtoReg, id_RegDst  in  1 each  controller outputs
- id_ALUsrc, id_ALUop, id_branch  in  2 each  controller outputs
- id_flush  in  1  controller request to flush IF/ID (taken branch or jump)
- id_rd1, id_rd2, id_imm  in  W each  register file read data and sign-extended immediate
- id_rs, id_rt, id_rd  in  5 each  register numbers of the instruction in ID
- mem_RegWrite, mem_Mem_Read  in  1 each  EX/MEM control
- mem_write_reg  in  5  EX/MEM destination register
- ex_RegWrite, ex_Mem_Read, ex_Mem_Write, ex_MemtoReg, ex_RegDst  out  1 each  registered control
- ex_ALUsrc, ex_ALUop  out  2 each  registered control
- ex_rd1, ex_rd2, ex_imm  out  W each  registered operands
- ex_rs, ex_rt, ex_rd  out  5 each  registered register numbers
- stall  out  1  combinational hazard indication
- pc_write, ifid_write  out  1 each  equal to ~stall
- ifid_flush  out  1  equal to id_flush & ~stall
- stall_cnt, flush_cnt  out  CW each  saturating event counters

Behaviour:
- Reset (rst=0, asynchronous): every ex_* output is 0, so the EX stage holds a NOP bubble. stall_cnt and flush_cnt are 0.
- ex_write_reg (internal) = ex_RegDst ? ex_rd : ex_rt.
- Register 0 never causes a hazard.
- load_use = ex_Mem_Read & (ex_rt != 0) & (ex_rt == id_rs | ex_rt == id_rt).
- br = (id_branch != 0).
- br_ex = br & ex_RegWrite & (ex_write_reg != 0) & (ex_write_reg == id_rs | ex_write_reg == id_rt).
- br_mem = br & mem_Mem_Read & mem_RegWrite & (mem_write_reg != 0) & (mem_write_reg == id_rs | mem_write_reg == id_rt).
- stall = load_use | br_ex | br_mem. This path is purely combinational from the current inputs and registers.
- Rising edge, stall=1:
  - All control outputs load 0 (bubble).
  - Data and register-number outputs also load 0.
  - pc_write = ifid_write = 0 and ifid_flush = 0, because eq is stale and the branch re-evaluates next cycle.
- Rising edge, stall=0: every ex_* output loads its id_* counterpart. Latency is exactly 1 cycle.
- id_branch is consumed in ID and is not forwarded to EX.
- id_flush with stall=0: ifid_flush=1 and the branch/jump itself advances normally into EX.
- Back-to-back stalls:
  - A load followed by a dependent beq stalls 2 cycles: br_ex for the load in EX, then br_mem for the load in MEM.
  - Each stalled cycle inserts one bubble.
- Counters:
  - stall_cnt increments on each edge where stall=1.
  - flush_cnt increments on each edge where ifid_flush=1.
  - Both saturate at 2^CW-1 and never wrap.
- Reset asserted mid-stall clears outputs immediately. The first post-reset cycle re-evaluates hazards from the reset (zero) EX state, so no stall arises from EX.
- No X propagation: all outputs are defined whenever rst=0 or after the first edge.

Test Plan:
- Reset then release; drive add (RegDst=1, RegWrite=1, ALUop=10, rd1=5, rd2=7, rd=3) -> after 1 edge ex_RegWrite=1, ex_ALUop=10, ex_rd1=5, ex_rd2=7, ex_rd=3; stall=0 throughout.
- lw $2 in EX (ex_Mem_Read=1, ex_rt=2), ID add rs=2 -> stall=1, pc_write=0. Next edge all ex_* = 0 and stall_cnt=1. Next cycle stall=0 and the add passes.
- lw $0 in EX, ID uses rs=0 -> stall=0 and no bubble.
- lw $4 then beq rs=4 with id_flush=1 -> stall for 2 cycles (br_ex, then br_mem with mem_write_reg=4), ifid_flush=0 in both. Third cycle ifid_flush=1, flush_cnt=1, stall_cnt=2.
- Jump (id_flush=1, no hazard) -> ifid_flush=1 same cycle, pc_write=1, flush_cnt increments by 1.
- CW=2, force 5 consecutive stalls -> stall_cnt reads 1, 2, 3, 3, 3. Assert rst=0 mid-sequence -> stall_cnt=0 and ex_* = 0 immediately, without waiting for a clock edge.
